// File: rtl/seg7_hist_scan.sv
// Keeps the last four captured nibbles and shows them as hex on a 4-digit common-anode mux display.
// Display outputs lag pc/idx/HIST by one clock; DIN_VALID is never back-pressured.
// Define SEG7_UNUSED_BLANK_EN to keep digit positions beyond NVALID dark (digit 0 always lit).
module seg7_hist_scan #(
    parameter logic [15:0] SCAN_DIV  = 16'd50000,
    parameter logic [15:0] BLANK_CYC = 16'd16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  DIN,
    input  logic        DIN_VALID,
    input  logic        CLR,
    output logic [6:0]  SEG,
    output logic [3:0]  DIG,
    output logic [15:0] HIST,
    output logic [2:0]  NVALID
);

    logic [15:0] pc;
    logic [1:0]  idx;
    logic [3:0]  nib;
    logic        lit;

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign nib = HIST[{idx, 2'b00} +: 4];

    always_comb begin
        lit = (pc >= BLANK_CYC);
`ifdef SEG7_UNUSED_BLANK_EN
        if (idx != 2'd0 && {1'b0, idx} >= NVALID)
            lit = 1'b0;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc     <= 16'd0;
            idx    <= 2'd0;
            HIST   <= 16'h0000;
            NVALID <= 3'd0;
            SEG    <= 7'h7F;
            DIG    <= 4'hF;
        end else begin
            if (pc == SCAN_DIV - 16'd1) begin
                pc  <= 16'd0;
                idx <= idx + 2'd1;
            end else begin
                pc <= pc + 16'd1;
            end

            // Clear beats a coincident capture
            if (CLR) begin
                HIST   <= 16'h0000;
                NVALID <= 3'd0;
            end else if (DIN_VALID) begin
                HIST   <= {HIST[11:0], DIN};
                NVALID <= (NVALID == 3'd4) ? 3'd4 : NVALID + 3'd1;
            end

            if (lit) begin
                DIG <= ~(4'b0001 << idx);
                SEG <= decode(nib);
            end else begin
                DIG <= 4'hF;
                SEG <= 7'h7F;
            end
        end
    end

endmodule
